// File: rtl/hex_scan_pkg.sv
// Shared constants and helpers for the hex_scan display controller and its
// prescaler.
package hex_scan_pkg;

   localparam int MAX_DIGITS = 8;
   localparam int NIBBLE_W   = 4;

   // Segment pattern the downstream decoder drives for a suppressed digit.
   localparam logic [6:0] BLANK_SEG = 7'b1111111;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < n) begin
            r = i + 1;
         end else begin
            r = r;
         end
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/hex_scan_if.sv
// Capture/display bus between the value datapath, hex_scan and the segment
// decoder.
interface hex_scan_if #(parameter int DIGITS = 8);

   logic                                      load_i;
   logic [hex_scan_pkg::NIBBLE_W*DIGITS-1:0]  data_i;
   logic [DIGITS-1:0]                         mask_i;
   logic [hex_scan_pkg::NIBBLE_W-1:0]         nibble_o;
   logic [DIGITS-1:0]                         an_o;
   logic                                      blank_o;
   logic [2:0]                                digit_o;

   modport master (
      output load_i, data_i, mask_i,
      input  nibble_o, an_o, blank_o, digit_o
   );

   modport slave (
      input  load_i, data_i, mask_i,
      output nibble_o, an_o, blank_o, digit_o
   );

endinterface

// File: rtl/hex_scan_tick.sv
// scan_tick: free-running DIV prescaler; tick_o is high during the cycle in
// which the count sits at DIV-1. Reusable by other display/debounce blocks.
module scan_tick
   import hex_scan_pkg::*;
#(
   parameter int DIV   = 50000,
   parameter int CNT_W = clog2(DIV)
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             tick_o,
   output logic [CNT_W-1:0] cnt_o
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             tick_r;

   // Next count value, wrapping after DIV-1.
   always_comb begin
      cnt_nxt_s = (cnt_r == LAST) ? {CNT_W{1'b0}} : cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   // Count register; tick is registered alongside so it marks the wrap cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r  <= {CNT_W{1'b0}};
         tick_r <= (LAST == {CNT_W{1'b0}});
      end else begin
         cnt_r  <= cnt_nxt_s;
         tick_r <= (cnt_nxt_s == LAST);
      end
   end

   assign tick_o = tick_r;
   assign cnt_o  = cnt_r;

endmodule

// File: rtl/hex_scan.sv
// hex_scan: time-multiplexed 7-segment digit scanner. Optional leading-zero
// blanking is enabled by defining HEX_SCAN_LZB_EN.
module hex_scan
   import hex_scan_pkg::*;
#(
   parameter int DIGITS = 8,
   parameter int DIV    = 50000
) (
   input  logic     clk,
   input  logic     rst_n,
   hex_scan_if.slave bus
);

   localparam int                CNT_W    = clog2(DIV);
   localparam int                IDX_W    = 3;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DIV - 1);

   logic [NIBBLE_W*DIGITS-1:0] data_r;
   logic [DIGITS-1:0]          mask_r;
   logic [IDX_W-1:0]           idx_r;
   logic                       tick_s;
   logic [CNT_W-1:0]           cnt_s;
   logic                       step_s;
   logic [DIGITS-1:0]          sel_s;
   logic [DIGITS-1:0]          lzb_s;
   logic [NIBBLE_W-1:0]        nib_s;
   logic                       show_s;
   logic [DIGITS-1:0]          an_s;

   scan_tick #(.DIV(DIV), .CNT_W(CNT_W)) u_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick_o (tick_s),
      .cnt_o  (cnt_s)
   );

   // A digit advance needs both the tick flag and the count at its wrap value,
   // so a single upset register cannot skip a dwell slot.
   assign step_s = tick_s & (cnt_s == LAST_CNT);

   // Capture of display content and digit index stepping.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_r <= {(NIBBLE_W*DIGITS){1'b0}};
         mask_r <= {DIGITS{1'b1}};
         idx_r  <= {IDX_W{1'b0}};
      end else begin
         if (bus.load_i) begin
            data_r <= bus.data_i;
            mask_r <= bus.mask_i;
         end
         if (step_s) begin
            idx_r <= (idx_r == LAST_IDX) ? {IDX_W{1'b0}} : idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
         end
      end
   end

`ifdef HEX_SCAN_LZB_EN
   logic zero_s;

   // Digit k>0 is blanked when it and every nibble above it are zero.
   always_comb begin
      zero_s = 1'b1;
      lzb_s  = {DIGITS{1'b0}};
      for (int k = DIGITS - 1; k >= 1; k--) begin
         zero_s   = zero_s & (data_r[k*NIBBLE_W +: NIBBLE_W] == {NIBBLE_W{1'b0}});
         lzb_s[k] = zero_s;
      end
   end
`else
   assign lzb_s = {DIGITS{1'b0}};
`endif

   // One-hot digit select, nibble mux and visibility, all from registers.
   always_comb begin
      sel_s = {DIGITS{1'b0}};
      nib_s = {NIBBLE_W{1'b0}};
      for (int k = 0; k < DIGITS; k++) begin
         sel_s[k] = (idx_r == IDX_W'(k));
         nib_s    = nib_s | ({NIBBLE_W{sel_s[k]}} & data_r[k*NIBBLE_W +: NIBBLE_W]);
      end
      show_s = |(sel_s & mask_r & ~lzb_s);
      an_s   = show_s ? ~sel_s : {DIGITS{1'b1}};
   end

   assign bus.nibble_o = nib_s;
   assign bus.an_o     = an_s;
   assign bus.blank_o  = ~show_s;
   assign bus.digit_o  = idx_r;

endmodule

// File: tb/tb_hex_scan.sv
// Directed self-checking bench for hex_scan: a DIGITS=4/DIV=3 instance and a
// DIGITS=8/DIV=1 instance, with hand-computed expected values.
module tb_hex_scan;

   logic clk = 1'b0;
   logic rst4_n;
   logic rst8_n;

   int errors = 0;
   int checks = 0;
   int t      = 0;

`ifdef HEX_SCAN_LZB_EN
   localparam logic [3:0] VIS70 = 4'b0011;
   localparam logic [3:0] VIS00 = 4'b0001;
`else
   localparam logic [3:0] VIS70 = 4'b1111;
   localparam logic [3:0] VIS00 = 4'b1111;
`endif

   logic [3:0] an4_tbl [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
   logic [7:0] an8_tbl [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

   always #5 clk = ~clk;

   hex_scan_if #(.DIGITS(4)) b4 ();
   hex_scan_if #(.DIGITS(8)) b8 ();

   hex_scan #(.DIGITS(4), .DIV(3)) u4 (
      .clk   (clk),
      .rst_n (rst4_n),
      .bus   (b4)
   );

   hex_scan #(.DIGITS(8), .DIV(1)) u8 (
      .clk   (clk),
      .rst_n (rst8_n),
      .bus   (b8)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      t++;
   endtask

   // Walks n cycles of the 4-digit instance; idx follows t since the last reset.
   task automatic scan_check(input string tag, input int n, input logic [15:0] d,
                             input logic [3:0] vis);
      int idx;
      for (int i = 0; i < n; i++) begin
         step();
         b4.load_i = 1'b0;
         idx = (t / 3) % 4;
         check({tag, "_nib"},   32'(b4.nibble_o), 32'(d[idx*4 +: 4]));
         check({tag, "_an"},    32'(b4.an_o),     32'(vis[idx] ? an4_tbl[idx] : 4'hF));
         check({tag, "_blank"}, 32'(b4.blank_o),  32'(!vis[idx]));
         check({tag, "_digit"}, 32'(b4.digit_o),  32'(idx));
      end
   endtask

   initial begin
      rst4_n    = 1'b0;
      rst8_n    = 1'b0;
      b4.load_i = 1'b0;
      b4.data_i = 16'h0;
      b4.mask_i = 4'h0;
      b8.load_i = 1'b0;
      b8.data_i = 32'h0;
      b8.mask_i = 8'h0;
      repeat (2) @(negedge clk);

      rst4_n = 1'b1;
      t      = 0;
      check("rst_an",    32'(b4.an_o),     32'h0000_000E);
      check("rst_nib",   32'(b4.nibble_o), 32'h0);
      check("rst_digit", 32'(b4.digit_o),  32'h0);
      check("rst_blank", 32'(b4.blank_o),  32'h0);

      b4.load_i = 1'b1;
      b4.data_i = 16'hA5C3;
      b4.mask_i = 4'hF;
      scan_check("scan", 13, 16'hA5C3, 4'hF);

      b4.load_i = 1'b1;
      b4.mask_i = 4'b0101;
      scan_check("mask", 12, 16'hA5C3, 4'b0101);

      step();
      check("coll_pre_digit", 32'(b4.digit_o), 32'h0);
      b4.load_i = 1'b1;
      b4.data_i = 16'h1234;
      b4.mask_i = 4'hF;
      scan_check("coll", 4, 16'h1234, 4'hF);

      b4.load_i = 1'b1;
      b4.data_i = 16'h0070;
      scan_check("lzb70", 12, 16'h0070, VIS70);

      b4.load_i = 1'b1;
      b4.data_i = 16'h0000;
      scan_check("lzb00", 12, 16'h0000, VIS00);

      b4.load_i = 1'b1;
      b4.data_i = 16'hA5C3;
      step();
      b4.load_i = 1'b0;
      check("prerst_nib", 32'(b4.nibble_o), 32'h5);
      rst4_n = 1'b0;
      step();
      rst4_n = 1'b1;
      t      = 0;
      check("midrst_an",    32'(b4.an_o),     32'h0000_000E);
      check("midrst_nib",   32'(b4.nibble_o), 32'h0);
      check("midrst_digit", 32'(b4.digit_o),  32'h0);
      check("midrst_blank", 32'(b4.blank_o),  32'h0);
      step();
      step();
      check("midrst_hold_an", 32'(b4.an_o), 32'h0000_000E);
      step();
      check("midrst_step_an", 32'(b4.an_o), 32'h0000_000D);

      rst8_n    = 1'b1;
      b8.load_i = 1'b1;
      b8.data_i = 32'h7654_3210;
      b8.mask_i = 8'hFF;
      check("d8_rst_an",  32'(b8.an_o),     32'h0000_00FE);
      check("d8_rst_nib", 32'(b8.nibble_o), 32'h0);
      for (int k = 1; k <= 9; k++) begin
         step();
         b8.load_i = 1'b0;
         check("d8_nib",   32'(b8.nibble_o), 32'(k % 8));
         check("d8_digit", 32'(b8.digit_o),  32'(k % 8));
         check("d8_an",    32'(b8.an_o),     32'(an8_tbl[k % 8]));
         check("d8_blank", 32'(b8.blank_o),  32'h0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hex_scan.md
Name: hex_scan

Overview:
- Time-multiplexed scan controller for a bank of common-anode 7-segment digits.
- Captures a packed multi-digit hex word and steps through the digits at a fixed dwell period.
- Per digit, presents the 4-bit nibble to the downstream hex-to-segment decoder and drives the active-low digit-select lines.
- Sits between the datapath that produces display values and the segment decoder.

Parameters:
- DIGITS, 8, number of digits scanned; legal range 2..8.
- DIV, 50000, clock cycles each digit stays selected; legal range >= 1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous reset, active-low
- load_i  input  1  capture strobe for data_i and mask_i
- data_i  input  4*DIGITS  packed nibbles; digit k = data_i[4k+3:4k], digit 0 rightmost
- mask_i  input  DIGITS  per-digit enable; 1 = digit shown
- nibble_o  output  4  nibble of the currently selected digit, to the decoder
- an_o  output  DIGITS  digit select, active-low, at most one bit low
- blank_o  output  1  1 = current digit suppressed; downstream forces segments to all-ones
- digit_o  output  3  index of the currently selected digit

Behaviour:
- Reset is synchronous and active-low: rst_n sampled low on a clk edge resets all state. Single clock domain.
- State registers: data_q, mask_q, prescaler cnt (ceil(log2 DIV) bits, min 1), idx.
- Reset values: data_q=0, mask_q=all ones, cnt=0, idx=0.
  - Resulting outputs: nibble_o=0, digit_o=0, an_o=~1 (only bit 0 low), blank_o=0.
- All outputs are decoded from registers only; there is no combinational path from any input to any output.
- Capture: load_i high at an edge writes data_q<=data_i and mask_q<=mask_i. nibble_o, an_o and blank_o reflect the new values in the following cycle.
- Prescaler:
  - cnt increments every cycle; at cnt==DIV-1 it wraps to 0 and asserts internal tick for that cycle.
  - DIV=1 gives a tick every cycle.
- Digit step: on tick, idx<=idx+1, with DIGITS-1 wrapping to 0. Each digit is selected for exactly DIV cycles; full frame = DIGITS*DIV cycles.
- Selection:
  - nibble_o = data_q[4*idx+3:4*idx]; digit_o = idx.
  - If mask_q[idx]=1: an_o has only bit idx low, blank_o=0.
  - If mask_q[idx]=0: an_o all ones, blank_o=1.
  - The dwell slot is still consumed when the digit is masked (uniform brightness).
- Simultaneous load_i and tick: both take effect. The next cycle shows the new data at the new idx.
- Load mid-dwell: cnt and idx are unaffected; only the displayed content changes.
- Reset mid-scan: returns to digit 0 with cnt=0 on the next edge; captured data is lost.
- Unused digit_o bits (DIGITS<8) read 0 by construction; idx never exceeds DIGITS-1.

Optional Feature:
- Macro: HEX_SCAN_LZB_EN (leading-zero blanking).
- Defined: digit k>0 is additionally blanked when data_q nibbles k..DIGITS-1 are all zero.
  - Blanked digit: an_o all ones, blank_o=1.
  - Digit 0 is never blanked by this rule. mask_q still applies on top.
- Undefined: blanking is controlled by mask_q only; no extra logic is synthesised.

Decomposition:
- Shared package hex_scan_pkg holds:
  - MAX_DIGITS=8 and NIBBLE_W=4;
  - the blank segment pattern 7'b1111111 used downstream;
  - the function clog2 used for cnt width.
- One sub-module: scan_tick, a parameterised DIV prescaler with outputs tick_o and cnt_o. It is reusable by other display/debounce blocks.
- Digit indexing, capture and blanking stay in hex_scan.

Test Plan (DIGITS=4, DIV=3 unless stated):
- Reset: hold rst_n=0 for 2 edges, release -> an_o=4'b1110, nibble_o=0, digit_o=0, blank_o=0. an_o=4'b1101 appears exactly 3 cycles later.
- Scan order: load data_i=16'hA5C3, mask_i=4'hF -> nibble_o sequence 3,C,5,A, each for 3 cycles. an_o follows 1110,1101,1011,0111, then wraps to 1110.
- Masking: load mask_i=4'b0101 -> while idx=1 and idx=3, an_o=4'b1111 and blank_o=1 for the full 3 cycles. Digits 0 and 2 are shown normally.
- Load/tick collision: assert load_i with data_i=16'h1234 on the tick cycle while at idx=0 -> next cycle digit_o=1, nibble_o=3. cnt restarts at 0.
- DIV=1, DIGITS=8: load 32'h76543210 -> nibble_o steps 0..7 on consecutive cycles. an_o one-cold rotates every cycle.
- With HEX_SCAN_LZB_EN: load 16'h0070, mask 4'hF -> digits 3 and 2 blanked (blank_o=1), digits 1 and 0 shown (7 and 0). Loading 16'h0000 -> only digit 0 shown.
